// File: rtl/icache_mem_latency_guard_pkg.sv
// Shared types and constants for the icache memory-latency guard.
// The response struct is sized for the widest supported data bus; users slice it down to DataW.
package icache_mem_latency_guard_pkg;

    localparam int unsigned CNT_W      = 3;
    localparam int unsigned MAX_DATA_W = 64;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] rdata;
        logic                  err;
    } resp_t;

    localparam logic [MAX_DATA_W-1:0] SYNTH_ERR_DATA = 64'h0;

    function automatic int unsigned age_width(input int unsigned timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/icache_mem_timeout_timer.sv
// Age counter for the oldest live fetch: clears, counts while enabled,
// saturates at TimeoutCycles and flags expiry.
module icache_mem_timeout_timer
    import icache_mem_latency_guard_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned      AgeW   = age_width(TimeoutCycles);
    localparam logic [AgeW-1:0]  AgeMax = AgeW'(TimeoutCycles);

    logic [AgeW-1:0] r_age;

    // Age register; clear has priority over counting, count saturates at AgeMax
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_age <= {AgeW{1'b0}};
        end else if (i_clr) begin
            r_age <= {AgeW{1'b0}};
        end else if (i_en && (r_age != AgeMax)) begin
            r_age <= r_age + AgeW'(1);
        end else begin
            r_age <= r_age;
        end
    end

    assign o_expired = (r_age == AgeMax);

endmodule

// File: rtl/icache_mem_latency_guard.sv
// Bounds outstanding fetches and response latency between the icache and memory,
// synthesizing an error response on timeout and discarding the late real response.
module icache_mem_latency_guard
    import icache_mem_latency_guard_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TimeoutCycles  = 16,
    parameter int unsigned AddrW          = 32,
    parameter int unsigned DataW          = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             host_req_i,
    output logic             host_gnt_o,
    input  logic [AddrW-1:0] host_addr_i,
    output logic             host_rvalid_o,
    output logic [DataW-1:0] host_rdata_o,
    output logic             host_err_o,
    output logic             dev_req_o,
    input  logic             dev_gnt_i,
    output logic [AddrW-1:0] dev_addr_o,
    input  logic             dev_rvalid_i,
    input  logic [DataW-1:0] dev_rdata_i,
    input  logic             dev_err_i,
    output logic [2:0]       outstanding_o,
    output logic             timeout_o,
    output logic             protocol_err_o
);

    localparam int unsigned SumW = CNT_W + 1;

    logic [CNT_W-1:0] r_live;
    logic [CNT_W-1:0] r_drop;
    logic             r_perr;

    logic  w_full, w_accept, w_fwd, w_swallow, w_stray, w_tmo, w_host_resp;
    logic  w_expired, w_age_clr, w_age_en;
    logic  w_unused_rdata;
    resp_t w_resp;

    // Timed-out fetches still hold a device slot until their late response drains
    assign w_full     = (({1'b0, r_live} + {1'b0, r_drop}) == SumW'(MaxOutstanding));
    assign dev_req_o  = host_req_i & ~w_full;
    assign dev_addr_o = host_addr_i;
    assign host_gnt_o = dev_req_o & dev_gnt_i;
    assign w_accept   = host_gnt_o;

    // In-order responses: the oldest device requests are the dropped ones
    assign w_swallow   = dev_rvalid_i && (r_drop != 3'd0);
    assign w_fwd       = dev_rvalid_i && (r_drop == 3'd0) && (r_live != 3'd0);
    assign w_stray     = dev_rvalid_i && (r_drop == 3'd0) && (r_live == 3'd0);
    assign w_tmo       = !dev_rvalid_i && (r_live != 3'd0) && w_expired;
    assign w_host_resp = w_fwd | w_tmo;

    // A fetch granted while idle is already one cycle old on the next edge
    assign w_age_clr = w_host_resp | ((r_live == 3'd0) & ~w_accept);
    assign w_age_en  = (r_live != 3'd0) | w_accept;

    icache_mem_timeout_timer #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_clr     (w_age_clr),
        .i_en      (w_age_en),
        .o_expired (w_expired)
    );

    // Host response mux: forwarded data, synthesized error, or all-zero idle
    always_comb begin
        w_resp = '{rdata: SYNTH_ERR_DATA, err: 1'b0};
        if (w_fwd) begin
            w_resp.rdata = MAX_DATA_W'(dev_rdata_i);
            w_resp.err   = dev_err_i;
        end else if (w_tmo) begin
            w_resp.rdata = SYNTH_ERR_DATA;
            w_resp.err   = 1'b1;
        end else begin
            w_resp.rdata = SYNTH_ERR_DATA;
            w_resp.err   = 1'b0;
        end
    end

    assign host_rvalid_o  = w_host_resp;
    assign host_rdata_o   = w_resp.rdata[DataW-1:0];
    assign host_err_o     = w_resp.err;
    assign timeout_o      = w_tmo;
    assign outstanding_o  = r_live;
    assign protocol_err_o = r_perr;
    assign w_unused_rdata = ^w_resp.rdata;

    // Live/drop counters and sticky protocol error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_live <= 3'd0;
            r_drop <= 3'd0;
            r_perr <= 1'b0;
        end else begin
            r_live <= r_live + CNT_W'(w_accept) - CNT_W'(w_host_resp);
            r_drop <= r_drop + CNT_W'(w_tmo) - CNT_W'(w_swallow);
            r_perr <= r_perr | w_stray;
        end
    end

endmodule

// File: tb/tb_icache_mem_latency_guard.sv
// Directed scoreboard bench: stimulus pushes expected host responses, a negedge monitor pops and compares.
module tb_icache_mem_latency_guard;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        host_req_i;
    logic        host_gnt_o;
    logic [31:0] host_addr_i;
    logic        host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic        host_err_o;
    logic        dev_req_o;
    logic        dev_gnt_i;
    logic [31:0] dev_addr_o;
    logic        dev_rvalid_i;
    logic [31:0] dev_rdata_i;
    logic        dev_err_i;
    logic [2:0]  outstanding_o;
    logic        timeout_o;
    logic        protocol_err_o;

    icache_mem_latency_guard #(
        .MaxOutstanding (2),
        .TimeoutCycles  (4),
        .AddrW          (32),
        .DataW          (32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .host_req_i     (host_req_i),
        .host_gnt_o     (host_gnt_o),
        .host_addr_i    (host_addr_i),
        .host_rvalid_o  (host_rvalid_o),
        .host_rdata_o   (host_rdata_o),
        .host_err_o     (host_err_o),
        .dev_req_o      (dev_req_o),
        .dev_gnt_i      (dev_gnt_i),
        .dev_addr_o     (dev_addr_o),
        .dev_rvalid_i   (dev_rvalid_i),
        .dev_rdata_i    (dev_rdata_i),
        .dev_err_i      (dev_err_i),
        .outstanding_o  (outstanding_o),
        .timeout_o      (timeout_o),
        .protocol_err_o (protocol_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic        t;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic req, input logic [31:0] addr, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic er);
        host_req_i   = req;
        host_addr_i  = addr;
        dev_gnt_i    = gnt;
        dev_rvalid_i = rv;
        dev_rdata_i  = rd;
        dev_err_i    = er;
    endtask

    task automatic idle();
        drv(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic push(input logic [31:0] d, input logic e, input logic t);
        q.push_back('{d, e, t});
    endtask

    // Monitor: every host response must match the oldest expectation; idle cycles must be all-zero
    always @(negedge clk) begin
        if (rst_ni) begin
            if (host_rvalid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", {31'd0, host_rvalid_o}, 32'd0);
                end else begin
                    m_e = q.pop_front();
                    chk("rsp_rdata", host_rdata_o, m_e.d);
                    chk("rsp_err", {31'd0, host_err_o}, {31'd0, m_e.e});
                    chk("rsp_timeout", {31'd0, timeout_o}, {31'd0, m_e.t});
                end
            end else begin
                chk("idle_resp", {29'd0, timeout_o, host_err_o, |host_rdata_o}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0;
        idle();
        dev_gnt_i = 1'b0;
        step();
        @(negedge clk);
        chk("rst_outstanding", {29'd0, outstanding_o}, 32'd0);
        chk("rst_perr", {31'd0, protocol_err_o}, 32'd0);
        chk("rst_rvalid", {31'd0, host_rvalid_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        chk("rst_dev_req", {31'd0, dev_req_o}, 32'd0);
        step();
        rst_ni = 1'b1;
        idle();
        step();

        // 1: single fetch answered two cycles after grant
        drv(1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("s1_gnt", {31'd0, host_gnt_o}, 32'd1);
        chk("s1_dev_addr", dev_addr_o, 32'h0000_1000);
        step();
        idle();
        @(negedge clk);
        chk("s1_out1", {29'd0, outstanding_o}, 32'd1);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        push(32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("s1_out0", {29'd0, outstanding_o}, 32'd0);
        step();

        // 2: third request blocked while two are in flight
        drv(1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("s2_gnt0", {31'd0, host_gnt_o}, 32'd1);
        step();
        drv(1'b1, 32'h0000_2004, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("s2_gnt1", {31'd0, host_gnt_o}, 32'd1);
        chk("s2_out1", {29'd0, outstanding_o}, 32'd1);
        step();
        drv(1'b1, 32'h0000_2008, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("s2_full_req", {31'd0, dev_req_o}, 32'd0);
        chk("s2_full_gnt", {31'd0, host_gnt_o}, 32'd0);
        chk("s2_out2", {29'd0, outstanding_o}, 32'd2);
        step();
        drv(1'b1, 32'h0000_2008, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
        push(32'h1111_1111, 1'b0, 1'b0);
        @(negedge clk);
        chk("s2_rsp_cycle_req", {31'd0, dev_req_o}, 32'd0);
        step();
        drv(1'b1, 32'h0000_2008, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("s2_reopen_req", {31'd0, dev_req_o}, 32'd1);
        chk("s2_reopen_gnt", {31'd0, host_gnt_o}, 32'd1);
        chk("s2_out_after", {29'd0, outstanding_o}, 32'd1);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h2222_2222, 1'b1);
        push(32'h2222_2222, 1'b1, 1'b0);
        @(negedge clk);
        chk("s2_out2b", {29'd0, outstanding_o}, 32'd2);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h3333_3333, 1'b0);
        push(32'h3333_3333, 1'b0, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("s2_out0", {29'd0, outstanding_o}, 32'd0);
        step();

        // 3: timeout at cycle 4, late response at cycle 7 swallowed
        drv(1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        for (int i = 1; i < 4; i++) begin
            idle();
            @(negedge clk);
            chk("s3_waiting", {29'd0, outstanding_o}, 32'd1);
            step();
        end
        idle();
        push(32'h0, 1'b1, 1'b1);
        step();
        drv(1'b1, 32'h0000_3004, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("s3_out_after_tmo", {29'd0, outstanding_o}, 32'd0);
        chk("s3_gnt_with_drop", {31'd0, host_gnt_o}, 32'd1);
        step();
        drv(1'b1, 32'h0000_3008, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("s3_full_drop", {31'd0, dev_req_o}, 32'd0);
        step();
        drv(1'b1, 32'h0000_3008, 1'b1, 1'b1, 32'h7777_7777, 1'b0);
        @(negedge clk);
        chk("s3_swallow_req", {31'd0, dev_req_o}, 32'd0);
        step();
        drv(1'b1, 32'h0000_3008, 1'b0, 1'b1, 32'h55AA_55AA, 1'b0);
        push(32'h55AA_55AA, 1'b0, 1'b0);
        @(negedge clk);
        chk("s3_full_clear", {31'd0, dev_req_o}, 32'd1);
        chk("s3_no_gnt", {31'd0, host_gnt_o}, 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("s3_out0", {29'd0, outstanding_o}, 32'd0);
        step();

        // 4: real response exactly at the timeout cycle wins; 5: stray response sets sticky error
        drv(1'b1, 32'h0000_4000, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        repeat (3) begin
            idle();
            step();
        end
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
        push(32'hCAFE_F00D, 1'b0, 1'b0);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        @(negedge clk);
        chk("s4_out0", {29'd0, outstanding_o}, 32'd0);
        chk("s5_perr_before", {31'd0, protocol_err_o}, 32'd0);
        step();
        idle();
        @(negedge clk);
        chk("s5_perr_set", {31'd0, protocol_err_o}, 32'd1);
        step();
        @(negedge clk);
        chk("s5_perr_hold", {31'd0, protocol_err_o}, 32'd1);
        step();
        rst_ni = 1'b0;
        #1;
        chk("s5_rst_perr", {31'd0, protocol_err_o}, 32'd0);
        chk("s5_rst_out", {29'd0, outstanding_o}, 32'd0);
        step();
        rst_ni = 1'b1;
        step();

        // 6: accept + response in one cycle keeps count and restarts age
        drv(1'b1, 32'h0000_6000, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        drv(1'b1, 32'h0000_6004, 1'b1, 1'b1, 32'h0BAD_CAFE, 1'b0);
        push(32'h0BAD_CAFE, 1'b0, 1'b0);
        @(negedge clk);
        chk("s6_gnt", {31'd0, host_gnt_o}, 32'd1);
        chk("s6_out_same", {29'd0, outstanding_o}, 32'd1);
        step();
        for (int i = 2; i < 6; i++) begin
            idle();
            @(negedge clk);
            chk("s6_out_hold", {29'd0, outstanding_o}, 32'd1);
            step();
        end
        idle();
        push(32'h0, 1'b1, 1'b1);
        step();
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'h9999_9999, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("s6_out0", {29'd0, outstanding_o}, 32'd0);
        chk("s6_perr_clear", {31'd0, protocol_err_o}, 32'd0);
        step();

        // Mid-operation reset: the orphaned response is flagged
        drv(1'b1, 32'h0000_7000, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        idle();
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_out", {29'd0, outstanding_o}, 32'd0);
        step();
        rst_ni = 1'b1;
        drv(1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA_0000, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("mid_rst_perr", {31'd0, protocol_err_o}, 32'd1);
        step();

        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
